// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences writes into three rotating line buffers and flags complete 3x3 windows.
module line_buffer_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW = 10,
  parameter int RW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  output logic [2:0]    we_o,
  output logic [1:0]    top_sel_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          win_valid_o,
  output logic          busy_o,
  output logic          done_o
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    wr_idx_q, wr_idx_d;
  logic          win_valid_q, win_valid_d;
  logic          accept, last_col, start;
  always_comb begin
    busy_o      = (state_q == FILL) || (state_q == RUN);
    accept      = busy_o && pix_valid_i;
    start       = (state_q == IDLE) && start_i;
    last_col    = col_q == CW'(IMG_W - 1);
    win_valid_d = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    col_d       = start ? '0 : accept ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d       = start ? '0 : (accept && last_col) ? row_q + 1'b1 : row_q;
    wr_idx_d    = start ? 2'd0 : (accept && last_col) ? (wr_idx_q == 2'd2 ? 2'd0 : wr_idx_q + 2'd1) : wr_idx_q;
    state_d     = state_q;
    case (state_q)
      IDLE: state_d = start_i ? FILL : IDLE;
      FILL: state_d = (accept && last_col && row_q == RW'(1)) ? RUN : FILL;
      RUN:  state_d = (accept && last_col && row_q == RW'(IMG_H - 1)) ? DONE : RUN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    we_o        = accept ? 3'b001 << wr_idx_q : 3'b000;
    top_sel_o   = wr_idx_q == 2'd2 ? 2'd0 : wr_idx_q + 2'd1;
    col_o       = col_q;
    row_o       = row_q;
    win_valid_o = win_valid_q;
    done_o      = state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      wr_idx_q    <= 2'd0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_idx_q    <= wr_idx_d;
      win_valid_q <= win_valid_d;
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed and random frames checked against a pixel-count reference model.
module tb_line_buffer_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int CW = 2;
  localparam int RW = 3;
  logic          clk = 0;
  logic          rst = 0;
  logic          start_i = 0;
  logic          pix_valid_i = 0;
  logic [2:0]    we_o;
  logic [1:0]    top_sel_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          win_valid_o, busy_o, done_o;
  int checks = 0;
  int failures = 0;
  int n = 0;
  bit active = 0;
  bit in_done = 0;
  bit wv = 0;
  int wins = 0;
  line_buffer_ctrl #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
    .we_o(we_o), .top_sel_o(top_sel_o), .col_o(col_o), .row_o(row_o),
    .win_valid_o(win_valid_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h n=%0d t=%0t", tag, got, exp, n, $time);
    end
  endtask
  task automatic cycle(input bit s, input bit v, input bit r);
    int row, col;
    bit acc;
    @(negedge clk);
    rst = r;
    start_i = s;
    pix_valid_i = v;
    if (r) begin
      n = 0;
      active = 0;
      in_done = 0;
      wv = 0;
    end
    row = n / W;
    col = n % W;
    acc = active && v;
    #1;
    chk("we", 32'(we_o), acc ? 32'(1 << (row % 3)) : 0);
    chk("top_sel", 32'(top_sel_o), 32'((row % 3 + 1) % 3));
    chk("col", 32'(col_o), 32'(col % (1 << CW)));
    chk("row", 32'(row_o), 32'(row % (1 << RW)));
    chk("busy", 32'(busy_o), 32'(active));
    chk("done", 32'(done_o), 32'(in_done));
    chk("win_valid", 32'(win_valid_o), 32'(wv));
    if (win_valid_o) wins++;
    @(posedge clk);
    if (!r) begin
      wv = acc && row >= 2 && col >= 2;
      if (in_done) in_done = 0;
      else if (!active && s) begin
        active = 1;
        n = 0;
      end else if (acc) begin
        n++;
        if (n == W * H) begin
          active = 0;
          in_done = 1;
        end
      end
    end
  endtask
  initial begin
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    wins = 0;
    for (int i = 0; i < W * H; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("win_count_full", 32'(wins), 32'((H - 2) * (W - 2)));
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    wins = 0;
    for (int i = 0; i < 2 * W; i++) cycle(0, 1, 0);
    for (int i = 0; i < 2 * W; i++) begin
      cycle(0, 1, 0);
      cycle(i == 1, 0, 0);
    end
    for (int i = 0; i < W; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("win_count_gappy", 32'(wins), 32'((H - 2) * (W - 2)));
    cycle(1, 0, 0);
    for (int i = 0; i < 2 * W + 1; i++) cycle(0, 1, 0);
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < W * H; i++) cycle(0, 1, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
